// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: instruction width,
// PC increment, and default reset PC / NOP instruction words.
package if_stage_pkg;

  localparam int          INSTR_W           = 32;
  localparam logic [31:0] PC_INC            = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Flush has priority over freeze; flush loads a
// bubble (NOP, pc 0, invalid), freeze holds, otherwise the fetched
// instruction and its PC+4 are captured as valid.
import if_stage_pkg::*;

module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 freeze,
  input  logic [31:0]          d_pc,
  input  logic [INSTR_W-1:0]   d_instr,
  output logic [31:0]          q_pc,
  output logic [INSTR_W-1:0]   q_instr,
  output logic                 q_valid
);

  // IF/ID capture with flush > freeze > load priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_pc    <= 32'h0;
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_pc    <= 32'h0;
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (!freeze) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address and feeds the IF/ID register. Branch redirect beats freeze.
// Optional feature macro: IF_PERF_CNT_EN (fetch/stall/flush counters).
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
`ifdef IF_PERF_CNT_EN
  output logic        if_valid,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`else
  output logic        if_valid
`endif
);

  logic [31:0] pc_p0;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [1:0]  unused_branch_lsb;

  // Low address bits of a branch target are discarded; PC is word aligned.
  assign unused_branch_lsb = branch_addr[1:0];
  assign pc_plus4          = pc_p0 + PC_INC;
  assign imem_addr         = pc_p0;

  // Next-PC selection: redirect, then hold, then sequential
  always_comb begin
    pc_next = pc_plus4;
    if (branch_taken)
      pc_next = word_align(branch_addr);
    else if (freeze)
      pc_next = pc_p0;
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_p0 <= word_align(RESET_PC);
    else
      pc_p0 <= pc_next;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (branch_taken),
    .freeze  (freeze),
    .d_pc    (pc_plus4),
    .d_instr (imem_data),
    .q_pc    (if_pc),
    .q_instr (if_instr),
    .q_valid (if_valid)
  );

`ifdef IF_PERF_CNT_EN
  // Performance counters; all wrap silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch <= 32'h0;
      perf_stall <= 32'h0;
      perf_flush <= 32'h0;
    end else begin
      if (branch_taken)
        perf_flush <= perf_flush + 32'd1;
      else if (freeze)
        perf_stall <= perf_stall + 32'd1;
      else
        perf_fetch <= perf_fetch + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios from the fetch-stage
// behaviour plus randomized freeze/branch traffic against a reference model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [31:0] perf_fetch, perf_stall, perf_flush;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid;
  logic [31:0] m_fetch, m_stall, m_flush;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_0001;
      32'h0000_0004: return 32'hE3A0_1A01;
      32'h0000_0008: return 32'hE3A0_2103;
      32'h0000_000C: return 32'hE080_3001;
      default:       return a ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
`ifdef IF_PERF_CNT_EN
    .if_valid     (if_valid),
    .perf_fetch   (perf_fetch),
    .perf_stall   (perf_stall),
    .perf_flush   (perf_flush)
`else
    .if_valid     (if_valid)
`endif
  );

`ifndef IF_PERF_CNT_EN
  assign perf_fetch = 32'h0;
  assign perf_stall = 32'h0;
  assign perf_flush = 32'h0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0;
    m_fetch = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock edge of fetch-stage behaviour, from the stage's rules.
  task automatic model_edge(input logic frz, input logic br, input logic [31:0] ba);
    if (br) begin
      m_pc = ba & ~32'd3; m_ifpc = 0; m_instr = NOP; m_valid = 0;
      m_flush = m_flush + 1;
    end else if (frz) begin
      m_stall = m_stall + 1;
    end else begin
      m_instr = mem_word(m_pc); m_ifpc = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4;
      m_fetch = m_fetch + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".if_pc"},     if_pc,     m_ifpc);
    check({tag, ".if_instr"},  if_instr,  m_instr);
    check({tag, ".if_valid"},  {31'b0, if_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
    check({tag, ".perf_fetch"}, perf_fetch, m_fetch);
    check({tag, ".perf_stall"}, perf_stall, m_stall);
    check({tag, ".perf_flush"}, perf_flush, m_flush);
`endif
  endtask

  // Advance one edge with current inputs, then compare at the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(freeze, branch_taken, branch_addr);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic set_in(input logic frz, input logic br, input logic [31:0] ba);
    freeze = frz; branch_taken = br; branch_addr = ba;
  endtask

  // Assert reset between edges, verify immediate effect, release on negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all(tag);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 0, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Three free-running fetches
    for (int i = 0; i < 3; i++) tick("free");
    check("plan.addr12", imem_addr, 32'd12);
    check("plan.ifpc12", if_pc, 32'd12);
    check("plan.instr8", if_instr, 32'hE3A02103);
    check("plan.valid",  {31'b0, if_valid}, 32'd1);

    // Freeze for four cycles after the second fetch
    do_reset("rst_a");
    tick("f1");
    tick("f2");
    set_in(1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick("frz");
      check("frz.addr",  imem_addr, 32'd8);
      check("frz.instr", if_instr, 32'hE3A01A01);
      check("frz.ifpc",  if_pc, 32'd8);
    end
`ifdef IF_PERF_CNT_EN
    check("frz.perf_stall", perf_stall, 32'd4);
`endif
    set_in(0, 0, 32'h0);
    tick("rel");
    check("rel.instr", if_instr, 32'hE3A02103);
    check("rel.ifpc",  if_pc, 32'd12);

    // Branch to an unaligned target
    set_in(0, 1, 32'h0000_0076);
    tick("br");
    check("br.addr",  imem_addr, 32'h74);
    check("br.valid", {31'b0, if_valid}, 32'd0);
    check("br.instr", if_instr, NOP);
    set_in(0, 0, 32'h0);
    tick("br_tgt");
    check("br_tgt.instr", if_instr, mem_word(32'h74));
    check("br_tgt.ifpc",  if_pc, 32'h78);

    // Branch and freeze together
    do_reset("rst_b");
    set_in(1, 1, 32'h0000_0040);
    tick("brfrz");
    check("brfrz.addr",  imem_addr, 32'h40);
    check("brfrz.valid", {31'b0, if_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("brfrz.perf_flush", perf_flush, 32'd1);
    check("brfrz.perf_stall", perf_stall, 32'd0);
`endif
    set_in(0, 0, 32'h0);
    tick("brfrz_next");

    // PC wrap
    set_in(0, 1, 32'hFFFF_FFFF);
    tick("wrap_br");
    check("wrap_br.addr", imem_addr, 32'hFFFF_FFFC);
    set_in(0, 0, 32'h0);
    tick("wrap");
    check("wrap.addr", imem_addr, 32'h0);
    check("wrap.ifpc", if_pc, 32'h0);
    check("wrap.instr", if_instr, mem_word(32'hFFFF_FFFC));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(3) == 0), ($urandom_range(9) == 0), $urandom);
      tick("rand");
    end

    // Mid-stream asynchronous reset, then resume
    set_in(0, 0, 32'h0);
    tick("pre_rst");
    do_reset("rst_mid");
    for (int i = 0; i < 5; i++) tick("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on simulation time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the ARM pipeline. Owns the program counter, drives the word address into the instruction memory and captures the returned instruction into the IF/ID pipeline register for the decode stage. Supports hazard freeze from the hazard unit and branch redirect/flush from the execute stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall; hold PC and IF/ID.
- branch_taken  in  1  execute-stage branch resolved taken; redirect and flush.
- branch_addr  in  32  branch target byte address.
- imem_addr  out  32  byte address to instruction memory (= PC register).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- if_pc  out  32  IF/ID register: PC+4 of the captured instruction.
- if_instr  out  32  IF/ID register: captured instruction.
- if_valid  out  1  IF/ID register holds a real fetched instruction.
- perf_fetch, perf_stall, perf_flush  out  32 each  counters (IF_PERF_CNT_EN only).

## Operation
- PC register: bits [1:0] always 0; branch_addr[1:0] ignored.
- Next-PC priority per cycle: branch_taken -> {branch_addr[31:2],2'b00}; else freeze -> hold; else PC+4.
- PC+4 is a 32-bit unsigned add; 32'hFFFF_FFFC wraps to 32'h0000_0000, no flag.
- IF/ID priority: branch_taken -> if_instr=NOP_INSTR, if_pc=0, if_valid=0; else freeze -> hold all three; else if_instr=imem_data, if_pc=PC+4, if_valid=1.
- branch_taken together with freeze: branch wins (redirect and flush happen, freeze ignored that cycle).
- No state machine beyond the PC and IF/ID registers; stage is always fetching.

## Timing
- Reset (async, immediate): PC=RESET_PC, imem_addr=RESET_PC, if_instr=NOP_INSTR, if_pc=0, if_valid=0, counters=0. Reset asserted mid-operation overrides all inputs on the same instant.
- First edge after reset release with freeze=0: IF/ID holds instruction at RESET_PC, if_pc=RESET_PC+4, PC=RESET_PC+4.
- Fetch latency: one cycle from imem_addr to if_instr.
- Branch: edge with branch_taken=1 -> next cycle imem_addr=target, IF/ID bubble; target instruction visible in IF/ID one edge later.
- Freeze: held values are stable for every cycle freeze is high; release resumes from the held PC with no lost or duplicated fetch.

## Configuration
- IF_PERF_CNT_EN defined: three 32-bit wrapping counters, reset 0. perf_fetch +1 on each edge loading a valid instruction into IF/ID; perf_stall +1 on each edge with freeze=1 and branch_taken=0; perf_flush +1 on each edge with branch_taken=1.
- Undefined: counter ports and logic absent; remaining behaviour identical.

## Structure
- Shared package: NOP_INSTR default, instruction width constant (32), PC increment constant (4), reset PC constant.
- One sub-module: if_id_reg (IF/ID pipeline register with flush/freeze enables); PC register and next-PC mux live in if_stage.

## Test plan
- Reset then 3 free-running edges on the standard program -> imem_addr=12; IF/ID: if_pc=12, if_instr=32'hE3A02103, if_valid=1.
- freeze high 4 cycles after 2nd fetch -> imem_addr fixed at 8, if_instr=32'hE3A01A01, if_pc=8 throughout; on release next fetch is address 8; perf_stall=4.
- branch_taken with branch_addr=32'h0000_0076 -> next imem_addr=32'h74, if_valid=0, if_instr=NOP_INSTR; following edge captures word at 0x74, if_pc=0x78.
- branch_taken and freeze both high -> redirect and flush occur; perf_flush=1, perf_stall unchanged.
- Force PC to 32'hFFFF_FFFC via branch, one free edge -> imem_addr=0, if_pc=0.
- Assert rst mid-stream between edges -> outputs go to reset values immediately, before the next clk edge.
